sort_ctrl: RTL and testbench
============================

# sort_ctrl

Host-side controller that drives the `bubble_sort` core through a full batch. It accepts `NUM_DATA` words on a valid/ready input stream and loads them into the sorter. It then runs the sort, captures the sorter's free-running output burst into an internal FIFO, and replays the sorted words on a valid/ready output stream with a last marker. It sits between the streaming datapath and the sorter, so neither side has to know the sorter's load/compute/burst protocol.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (8): word width.
- `NUM_DATA`, default `` `NUM_DATA `` (8): words per batch, ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  controller accepts word.
- `in_data`  in  DATA_WIDTH  upstream word.
- `out_valid`  out  1  sorted word valid.
- `out_ready`  in  1  downstream accepts word.
- `out_data`  out  DATA_WIDTH  sorted word, ascending.
- `out_last`  out  1  high with the final word of a batch.
- `srt_rst`  out  1  synchronous reset to the sorter.
- `srt_wr_en`  out  1  sorter write strobe.
- `srt_datain`  out  DATA_WIDTH  sorter write data.
- `srt_rd_en`  out  1  sorter compute enable.
- `srt_done`  in  1  sorter finished; held high until `srt_rst`.
- `srt_dataout`  in  DATA_WIDTH  sorter burst output.

## Operation
- **Sorter contract:**
  - `srt_rst` clears the sorter's counters and `done`.
  - Each `srt_wr_en` cycle writes one word.
  - `srt_rd_en` must be high for the sort to advance.
  - Once `srt_done` is high, the sorter emits word k (ascending) on `srt_dataout` in cycle T+1+k, where T is the first cycle `srt_done` is high. The burst cannot be stalled.
- **States:** IDLE, LOAD, SORT, DRAIN, FLUSH.
- **IDLE:**
  - `srt_rst`=1 for exactly one cycle.
  - Next state LOAD.
- **LOAD:**
  - `in_ready`=1.
  - `srt_wr_en` = `in_valid`; `srt_datain` = `in_data` (combinational pass-through).
  - `wcnt` increments on each handshake.
  - Goes to SORT on the handshake where `wcnt` = NUM_DATA-1.
- **SORT:**
  - `srt_rd_en` = !`srt_done` (combinational).
  - When `srt_done`=1, goes to DRAIN and clears `wcnt`.
- **DRAIN:**
  - Pushes `srt_dataout` into the FIFO every cycle; `wcnt` increments each push.
  - After NUM_DATA pushes, goes to FLUSH.
- **FLUSH:**
  - Waits until the FIFO is empty and the last word has handshaken, then goes to IDLE.
- **Output:** the FIFO output drives `out_*` in every state, so the output runs concurrently with DRAIN. An output counter asserts `out_last` on output word NUM_DATA-1.
- **Widths:** `wcnt` and the output counter are $clog2(NUM_DATA)+1 bits and clear to 0 at each batch boundary. They never wrap within a batch.

## Timing
- **Reset values:**
  - State IDLE; all counters 0.
  - `in_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
  - `srt_wr_en`=0, `srt_rd_en`=0, `srt_rst`=1.
- **Reset mid-batch:** asserting `rst_n` low mid-batch aborts immediately; the FIFO is emptied and the sorter is reset via IDLE.
- **LOAD throughput:** one word per cycle. `in_valid` outside LOAD is ignored (`in_ready`=0).
- **FIFO latency:** registered; a word pushed in cycle t is visible on `out_*` in cycle t+1.
- **FIFO sizing:** depth NUM_DATA, so there is never an overflow under any `out_ready` pattern. With an empty FIFO, `out_valid`=0.
- **Back-to-back batches:** the next batch's LOAD starts 2 cycles after the last output handshake (one cycle in FLUSH, one in IDLE).
- **Stream rules:** `out_valid` and `out_data` stay stable while `out_valid`=1 and `out_ready`=0.

## Structure
- **`config_leetcode.vh`:** `DATA_WIDTH`, `NUM_DATA`, and the state encodings (3-bit localparams) live here, shared with `bubble_sort`.
- **Sub-module `sync_fifo`:**
  - Parameters: DATA_WIDTH, DEPTH.
  - Ports: push, pop, full, empty, registered head.
  - Reusable by other datapath blocks.
- **`sort_ctrl`:** holds the FSM and the counters.

## Test plan
- **Basic batch:** load 5,3,8,1,7,2,6,4 with `out_ready`=1 → `out_data` = 1..8 in 8 consecutive cycles, with `out_last` only on 8.
- **Input stalls:** drop `in_valid` for 3 cycles mid-load → exactly 8 `srt_wr_en` pulses, and the output is still sorted.
- **Output backpressure:** hold `out_ready`=0 through DRAIN → FIFO holds 8 words, no loss. On release, 1..8 emerge in order with `out_valid` stable while stalled.
- **Edge data:** all-equal data (0xAA ×8) → eight 0xAA; data 0xFF,0x00 alternating → four 0x00, then four 0xFF.
- **Reset mid-SORT:** pull `rst_n` low during SORT → all outputs take their reset values and `srt_rst`=1. A new batch then sorts correctly.
- **Back-to-back batches:** two consecutive batches → second LOAD begins 2 cycles after the first `out_last` handshake, and there are no stray `out_valid` pulses.

Source files
------------

// File: rtl/sort_ctrl_pkg.sv
// Shared word/batch sizing, controller state encodings and counter-width helper
// for sort_ctrl and the bubble_sort core it sequences.
package sort_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int NUM_DATA_DEF   = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SORT  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_SORT  = ST_SORT,
        S_DRAIN = ST_DRAIN,
        S_FLUSH = ST_FLUSH
    } state_e;

    // One spare bit so a counter can reach the batch size without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sort_ctrl_sync_fifo.sv
// Single-clock FIFO with a registered head word; a word pushed in cycle t is
// presented on head_o in cycle t+1. head_o reads zero while empty.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = head_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        if (do_push) wptr_d = ptr_inc(wptr_q);
        if (do_pop)  rptr_d = ptr_inc(rptr_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // The head register must track the word behind the current head; a
        // word pushed this cycle is not yet in mem_q, so bypass it.
        if (do_pop) begin
            if (cnt_q == CW'(1)) head_d = do_push ? push_data_i : '0;
            else                 head_d = mem_q[ptr_inc(rptr_q)];
        end else if (do_push && empty_o) begin
            head_d = push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/sort_ctrl.sv
// Batch controller for the bubble_sort core: streams NUM_DATA words in, runs
// the sort, captures the sorter's burst into a FIFO and replays it with last.
//
// state | meaning
// IDLE  | one-cycle sorter reset, counters cleared
// LOAD  | accept words from the input stream and write them into the sorter
// SORT  | hold the sorter's compute enable until it reports done
// DRAIN | capture the non-stallable output burst into the FIFO
// FLUSH | wait for the final word to leave the output stream
module sort_ctrl
    import sort_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_DATA   = NUM_DATA_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  srt_rst,
    output logic                  srt_wr_en,
    output logic [DATA_WIDTH-1:0] srt_datain,
    output logic                  srt_rd_en,
    input  logic                  srt_done,
    input  logic [DATA_WIDTH-1:0] srt_dataout
);

    localparam int            CW       = cnt_width(NUM_DATA);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_DATA - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         wcnt_q, wcnt_d;
    logic [CW-1:0]         ocnt_q, ocnt_d;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (NUM_DATA)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (srt_dataout),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    // The FIFO feeds the output stream in every state so replay overlaps DRAIN.
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_head;
    assign out_last   = out_valid && (ocnt_q == LAST_IDX);
    assign fifo_pop   = out_valid && out_ready;
    assign srt_datain = in_data;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        ocnt_d    = fifo_pop ? ocnt_q + CW'(1) : ocnt_q;
        in_ready  = 1'b0;
        srt_wr_en = 1'b0;
        srt_rd_en = 1'b0;
        srt_rst   = 1'b0;
        fifo_push = 1'b0;
        case (state_q)
            S_IDLE: begin
                srt_rst = 1'b1;
                wcnt_d  = '0;
                ocnt_d  = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                in_ready  = 1'b1;
                srt_wr_en = in_valid;
                if (in_valid) begin
                    wcnt_d = wcnt_q + CW'(1);
                    if (wcnt_q == LAST_IDX) state_d = S_SORT;
                end
            end
            S_SORT: begin
                srt_rd_en = !srt_done;
                if (srt_done) begin
                    wcnt_d  = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Depth equals the batch size, so full never gates a real push.
                fifo_push = !fifo_full;
                wcnt_d    = wcnt_q + CW'(1);
                if (wcnt_q == LAST_IDX) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (fifo_pop && out_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ocnt_q  <= ocnt_d;
        end
    end

endmodule

// File: tb/tb_sort_ctrl.sv
// Scoreboard bench for sort_ctrl with a behavioural bubble_sort stand-in.
module tb_sort_ctrl;

    localparam int DW = 8;
    localparam int N  = 8;

    typedef logic [DW-1:0] arr_t [N];
    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, out_last;
    logic [DW-1:0] in_data, out_data, srt_datain;
    logic          srt_rst, srt_wr_en, srt_rd_en;
    logic          srt_done = 1'b0;
    logic [DW-1:0] srt_dataout = '0;

    always #5 clk = ~clk;

    sort_ctrl #(.DATA_WIDTH(DW), .NUM_DATA(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .srt_rst     (srt_rst),
        .srt_wr_en   (srt_wr_en),
        .srt_datain  (srt_datain),
        .srt_rd_en   (srt_rd_en),
        .srt_done    (srt_done),
        .srt_dataout (srt_dataout)
    );

    // ---------------- sorter stand-in ----------------
    arr_t s_mem, s_sorted;
    int   s_cnt = 0, s_busy = 0, s_bidx = 0;

    function automatic arr_t sort_arr(input arr_t a);
        arr_t r = a;
        logic [DW-1:0] t;
        for (int i = 0; i < N - 1; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (r[j] > r[j+1]) begin t = r[j]; r[j] = r[j+1]; r[j+1] = t; end
        return r;
    endfunction

    always @(posedge clk) begin
        if (srt_rst) begin
            s_cnt <= 0; s_busy <= 0; s_bidx <= 0; srt_done <= 1'b0;
        end else begin
            if (srt_wr_en && s_cnt < N) begin
                s_mem[s_cnt] <= srt_datain;
                s_cnt <= s_cnt + 1;
            end
            if (srt_rd_en && s_cnt == N && !srt_done) begin
                s_busy <= s_busy + 1;
                if (s_busy == 4) begin
                    srt_done <= 1'b1;
                    s_sorted <= sort_arr(s_mem);
                end
            end
            if (srt_done && s_bidx < N) begin
                srt_dataout <= s_sorted[s_bidx];
                s_bidx <= s_bidx + 1;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [DW:0]   exp_q[$];
    req_t          rq[$];
    int            n_vec = 0, n_err = 0;
    int            cyc = 0;
    int            first_hs = 0, last_hs = 0, hs_idx = 0, rise_cyc = 0, wr_pulses = 0;
    logic          prev_stall = 1'b0, prev_in_ready = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, a, e, cyc);
        end
    endfunction

    always @(negedge clk) begin
        logic [DW:0] e;
        req_t r;
        while (rq.size() != 0) begin
            r = rq.pop_front();
            chk(r.name, r.act, r.exp);
        end
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) chk("stray_out_valid", 32'(out_valid), 32'd0);
                else if (out_ready) begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e[DW-1:0]));
                    chk("out_last", 32'(out_last), 32'(e[DW]));
                    if (hs_idx == 0) first_hs = cyc;
                    if (out_last) begin last_hs = cyc; hs_idx = 0; end
                    else hs_idx++;
                end
            end
            if (srt_wr_en) wr_pulses++;
            if (in_ready && !prev_in_ready) rise_cyc = cyc;
            prev_stall = out_valid && !out_ready;
        end else begin
            prev_stall = 1'b0;
        end
        prev_data     = out_data;
        prev_in_ready = in_ready;
    end

    // ---------------- stimulus ----------------
    task automatic req(input string name, input logic [31:0] a, input logic [31:0] e);
        req_t r;
        r.name = name; r.act = a; r.exp = e;
        rq.push_back(r);
    endtask

    task automatic expect_batch(input arr_t s);
        for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), s[i]});
    endtask

    task automatic load_batch(input arr_t w, input int stall_at);
        logic hs;
        for (int i = 0; i < N; i++) begin
            if (i == stall_at) begin
                in_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = w[i];
            hs = 1'b0;
            for (int t = 0; t < 400 && !hs; t++) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk);
                #1;
            end
            if (!hs) req("load_timeout", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        req(tag, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        @(negedge clk);
        req("rst_in_ready",  32'(in_ready),  32'd0);
        req("rst_out_valid", 32'(out_valid), 32'd0);
        req("rst_out_last",  32'(out_last),  32'd0);
        req("rst_out_data",  32'(out_data),  32'd0);
        req("rst_srt_wr_en", 32'(srt_wr_en), 32'd0);
        req("rst_srt_rd_en", 32'(srt_rd_en), 32'd0);
        req("rst_srt_rst",   32'(srt_rst),   32'd1);
    endtask

    arr_t w, s, s1, s2;
    int   w0, t;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        chk_reset_outputs();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // basic batch
        w = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd7, 8'd2, 8'd6, 8'd4};
        s = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        expect_batch(s);
        load_batch(w, -1);
        wait_empty("basic_drain");
        req("basic_consecutive", 32'(last_hs - first_hs), 32'd7);

        // input stalls mid-load
        w = '{8'd40, 8'd10, 8'd30, 8'd20, 8'd80, 8'd60, 8'd70, 8'd50};
        s = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        w0 = wr_pulses;
        expect_batch(s);
        load_batch(w, 4);
        wait_empty("stall_drain");
        req("stall_wr_pulses", 32'(wr_pulses - w0), 32'd8);

        // output backpressure through DRAIN
        out_ready = 1'b0;
        w = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        s = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        expect_batch(s);
        load_batch(w, -1);
        t = 0;
        while (!srt_done && t < 200) begin @(negedge clk); t++; end
        req("bp_done_seen", 32'(srt_done), 32'd1);
        repeat (N + 4) @(posedge clk);
        #1 in_valid = 1'b1;
        @(negedge clk);
        req("bp_valid_held", 32'(out_valid), 32'd1);
        req("bp_head", 32'(out_data), 32'd1);
        req("flush_in_ready", 32'(in_ready), 32'd0);
        req("flush_wr_en", 32'(srt_wr_en), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_empty("bp_drain");

        // all-equal data
        w = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        expect_batch(w);
        load_batch(w, -1);
        wait_empty("equal_drain");

        // alternating extremes
        w = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        expect_batch(s);
        load_batch(w, -1);
        wait_empty("alt_drain");

        // reset during SORT
        w = '{8'd9, 8'd1, 8'd4, 8'd7, 8'd3, 8'd6, 8'd2, 8'd5};
        load_batch(w, -1);
        t = 0;
        while (!srt_rd_en && t < 50) begin @(negedge clk); t++; end
        req("abort_sort_seen", 32'(srt_rd_en), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        w = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd7, 8'd5, 8'd3, 8'd1};
        s = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        expect_batch(s);
        load_batch(w, -1);
        wait_empty("post_reset_drain");

        // back-to-back batches
        w = '{8'd33, 8'd11, 8'd99, 8'd22, 8'd77, 8'd44, 8'd66, 8'd55};
        s1 = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd99};
        expect_batch(s1);
        load_batch(w, -1);
        w = '{8'd200, 8'd100, 8'd150, 8'd250, 8'd0, 8'd50, 8'd25, 8'd75};
        s2 = '{8'd0, 8'd25, 8'd50, 8'd75, 8'd100, 8'd150, 8'd200, 8'd250};
        expect_batch(s2);
        load_batch(w, -1);
        req("b2b_gap", 32'(rise_cyc - last_hs), 32'd2);
        wait_empty("b2b_drain");

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
